// File: rtl/queue_find_scan.sv
// Append-only entry queue with a find-with-equality scan that streams every matching entry.
// One entry compared per cycle; a presented match holds until match_ready, and pushes are refused while a scan runs.
module queue_find_scan #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       clear,
    input  logic                       start,
    input  logic [WIDTH-1:0]           key,
    output logic                       busy,
    output logic                       match_valid,
    input  logic                       match_ready,
    output logic [WIDTH-1:0]           match_data,
    output logic [$clog2(DEPTH)-1:0]   match_index,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] size
);

    localparam int IW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] entries [DEPTH];
    logic [SW-1:0]    size_q;
    logic [SW-1:0]    idx_q;
    logic [SW-1:0]    count_q;
    logic [WIDTH-1:0] key_q;

    logic push_acc;
    logic start_acc;
    logic at_end;
    logic hit;
    logic handshake;

    assign push_ready = (state == IDLE) && (size_q < SW'(DEPTH));
    assign push_acc   = push_valid && push_ready && !clear;
    assign start_acc  = (state == IDLE) && start && !clear;
    assign at_end     = (idx_q == size_q);
    // idx_q only reaches DEPTH when at_end, so the truncated read index is safe.
    assign hit        = (state == SCAN) && !at_end && (entries[idx_q[IW-1:0]] == key_q);
    assign handshake  = hit && match_ready;

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign match_valid = hit;
    assign match_data  = hit ? entries[idx_q[IW-1:0]] : '0;
    assign match_index = hit ? idx_q[IW-1:0] : '0;
    assign count       = count_q;
    assign size        = size_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_acc) state_nxt = SCAN;
            SCAN: if (at_end) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            size_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            key_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (clear) begin
                    size_q <= '0;
                end else if (push_acc) begin
                    size_q <= size_q + SW'(1);
                end
                if (start_acc) begin
                    key_q   <= key;
                    idx_q   <= '0;
                    count_q <= '0;
                end
            end else if (state == SCAN && !at_end) begin
                // A match stalls the index until it is taken downstream.
                if (!hit) begin
                    idx_q <= idx_q + SW'(1);
                end else if (handshake) begin
                    idx_q   <= idx_q + SW'(1);
                    count_q <= count_q + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_acc) begin
            entries[size_q[IW-1:0]] <= push_data;
        end
    end

endmodule

// File: tb/tb_queue_find_scan.sv
// Directed bench for queue_find_scan: push/clear behaviour, scans with and without stalls, reset mid-scan.
module tb_queue_find_scan;

    localparam logic [63:0] BAZ = 64'h0000_0000_0062_617A;
    localparam logic [63:0] QUX = 64'h0000_0000_0071_7578;
    localparam logic [63:0] FOO = 64'h0000_0000_0066_6F6F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_valid;
    logic        push_ready;
    logic [63:0] push_data;
    logic        clear;
    logic        start;
    logic [63:0] key;
    logic        busy;
    logic        match_valid;
    logic        match_ready;
    logic [63:0] match_data;
    logic [2:0]  match_index;
    logic        done;
    logic [3:0]  count;
    logic [3:0]  size;

    int checks = 0;
    int errors = 0;

    queue_find_scan #(.DEPTH(8), .WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .clear(clear), .start(start), .key(key), .busy(busy),
        .match_valid(match_valid), .match_ready(match_ready),
        .match_data(match_data), .match_index(match_index),
        .done(done), .count(count), .size(size)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [63:0] d);
        push_valid = 1'b1;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    // Starts a scan and follows it to done. Cycle n counts from the start cycle (n=0).
    // Matches must carry the key and arrive at indices first_idx, first_idx+stride, ...
    task automatic run_scan(input logic [63:0] k, input bit toggle, input int first_idx,
                            input int stride, output int done_at, output int nmatch);
        bit   stalled = 1'b0;
        logic [2:0] stall_idx = '0;
        int   zero_bad = 0;
        done_at = -1;
        nmatch  = 0;
        key   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (stalled) begin
                check("stall_hold_vld", {63'd0, match_valid}, 64'd1);
                check("stall_hold_idx", {61'd0, match_index}, {61'd0, stall_idx});
                check("stall_hold_dat", match_data, k);
            end
            stalled = 1'b0;
            if (!match_valid && (match_data != 0 || match_index != 0)) zero_bad++;
            if (done) begin
                done_at = n;
                break;
            end
            match_ready = toggle ? n[0] : 1'b1;
            if (match_valid) begin
                if (match_ready) begin
                    check("match_idx", {61'd0, match_index}, 64'(first_idx + stride * nmatch));
                    check("match_dat", match_data, k);
                    nmatch++;
                end else begin
                    stalled   = 1'b1;
                    stall_idx = match_index;
                end
            end
            tick();
        end
        match_ready = 1'b1;
        check("idle_outputs_zero", 64'(zero_bad), 64'd0);
    endtask

    int done_at;
    int nmatch;

    initial begin
        rst_n = 1'b0; push_valid = 1'b0; push_data = '0; clear = 1'b0;
        start = 1'b0; key = '0; match_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_push_ready", {63'd0, push_ready}, 64'd1);
        check("rst_busy",       {63'd0, busy}, 64'd0);
        check("rst_size",       {60'd0, size}, 64'd0);
        check("rst_count",      {60'd0, count}, 64'd0);
        check("rst_match_vld",  {63'd0, match_valid}, 64'd0);
        check("rst_done",       {63'd0, done}, 64'd0);

        // Two entries, first one matches: SCAN cycles 1..3, done on cycle 4.
        push(BAZ);
        push(QUX);
        check("t1_size", {60'd0, size}, 64'd2);
        run_scan(BAZ, 1'b0, 0, 1, done_at, nmatch);
        check("t1_done_at", 64'(done_at), 64'd4);
        check("t1_nmatch",  64'(nmatch), 64'd1);
        check("t1_count",   {60'd0, count}, 64'd1);
        check("t1_size2",   {60'd0, size}, 64'd2);
        tick();
        check("t1_idle_busy", {63'd0, busy}, 64'd0);
        tick();
        check("t1_count_hold", {60'd0, count}, 64'd1);

        // Empty queue: one SCAN cycle, done on cycle 2.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t2_size", {60'd0, size}, 64'd0);
        run_scan(BAZ, 1'b0, 0, 1, done_at, nmatch);
        check("t2_done_at", 64'(done_at), 64'd2);
        check("t2_nmatch",  64'(nmatch), 64'd0);
        check("t2_count",   {60'd0, count}, 64'd0);
        tick();

        // Full queue of identical entries, scanned with a toggling ready.
        for (int i = 0; i < 8; i++) push(FOO);
        push_valid = 1'b1;
        push_data  = BAZ;
        check("t3_full_ready", {63'd0, push_ready}, 64'd0);
        tick();
        push_valid = 1'b0;
        check("t3_size_full", {60'd0, size}, 64'd8);
        run_scan(FOO, 1'b1, 0, 1, done_at, nmatch);
        check("t3_nmatch",  64'(nmatch), 64'd8);
        check("t3_done_at", 64'(done_at), 64'd17);
        check("t3_count",   {60'd0, count}, 64'd8);
        check("t3_size",    {60'd0, size}, 64'd8);
        tick();

        // Push together with clear in IDLE: clear wins.
        push_valid = 1'b1; push_data = BAZ; clear = 1'b1;
        tick();
        push_valid = 1'b0; clear = 1'b0;
        check("t4_clear_wins", {60'd0, size}, 64'd0);
        push(BAZ);
        push(QUX);
        push(BAZ);
        key = QUX; start = 1'b1; match_ready = 1'b0;
        tick();
        start = 1'b0;
        // Index 0 mismatches; push, start and clear during SCAN are all ignored.
        push_valid = 1'b1; push_data = FOO; start = 1'b1; key = BAZ; clear = 1'b1;
        check("t4_scan_push_ready", {63'd0, push_ready}, 64'd0);
        tick();
        push_valid = 1'b0; start = 1'b0; clear = 1'b0;
        check("t4_stall_vld", {63'd0, match_valid}, 64'd1);
        check("t4_stall_idx", {61'd0, match_index}, 64'd1);
        check("t4_stall_dat", match_data, QUX);
        tick();
        check("t4_hold_idx",  {61'd0, match_index}, 64'd1);
        check("t4_size",      {60'd0, size}, 64'd3);

        // Reset while the match is stalled.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_busy",      {63'd0, busy}, 64'd0);
        check("t5_match_vld", {63'd0, match_valid}, 64'd0);
        check("t5_size",      {60'd0, size}, 64'd0);
        check("t5_count",     {60'd0, count}, 64'd0);
        check("t5_done",      {63'd0, done}, 64'd0);
        match_ready = 1'b1;

        // Single match in the middle, mismatches on both sides: done on cycle 5.
        push(BAZ);
        push(QUX);
        push(BAZ);
        run_scan(QUX, 1'b0, 1, 1, done_at, nmatch);
        check("t6_done_at", 64'(done_at), 64'd5);
        check("t6_nmatch",  64'(nmatch), 64'd1);
        check("t6_count",   {60'd0, count}, 64'd1);
        check("t6_size",    {60'd0, size}, 64'd3);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/queue_find_scan.md
QUEUE_FIND_SCAN -- requirements
Module: queue_find_scan

Interface
REQ-001 SHALL have parameter DEPTH, default 8, maximum number of stored entries (power of two, >=2).
REQ-002 SHALL have parameter WIDTH, default 64, entry width in bits (8 ASCII characters, right-justified, zero-padded).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port push_valid  input  1  push_back request.
REQ-006 SHALL have port push_ready  output  1  push accepted this cycle when high together with push_valid.
REQ-007 SHALL have port push_data  input  WIDTH  entry to append.
REQ-008 SHALL have port clear  input  1  empty the queue.
REQ-009 SHALL have port start  input  1  begin find-with-equality scan.
REQ-010 SHALL have port key  input  WIDTH  comparison value, captured on accepted start.
REQ-011 SHALL have port busy  output  1  high in SCAN or DONE.
REQ-012 SHALL have port match_valid  output  1  a matching entry is presented.
REQ-013 SHALL have port match_ready  input  1  downstream accepts the match.
REQ-014 SHALL have port match_data  output  WIDTH  matching entry value.
REQ-015 SHALL have port match_index  output  $clog2(DEPTH)  queue position of the match.
REQ-016 SHALL have port done  output  1  one-cycle pulse ending a scan.
REQ-017 SHALL have port count  output  $clog2(DEPTH+1)  matches found by the latest scan.
REQ-018 SHALL have port size  output  $clog2(DEPTH+1)  current number of stored entries.

Function
REQ-019 SHALL implement states IDLE, SCAN, DONE.
REQ-020 SHALL set push_ready = (state==IDLE) && (size<DEPTH); an accepted push writes entry[size] and increments size next cycle.
REQ-021 SHALL, in IDLE, empty the queue (size=0) on clear; clear SHALL take priority over a simultaneous push, and SHALL be ignored outside IDLE.
REQ-022 SHALL, on start in IDLE with clear low, capture key, reset scan index to 0, zero count, and enter SCAN next cycle; start outside IDLE or with clear high SHALL be ignored.
REQ-023 SHALL, in SCAN with index<size, compare entry[index] with the captured key over all WIDTH bits.
REQ-024 SHALL, on mismatch, advance index by 1 in one cycle with match_valid low.
REQ-025 SHALL, on match, drive match_valid=1, match_data=entry[index], match_index=index combinationally from state and hold them stable until match_ready; on the handshake cycle SHALL advance index and increment count.
REQ-026 SHALL, in SCAN with index==size (including size==0), move to DONE next cycle.
REQ-027 SHALL assert done for exactly the single DONE cycle, then return to IDLE.
REQ-028 SHALL hold count stable from DONE until the next accepted start; count SHALL never exceed size.
REQ-029 SHALL leave stored entries and size unchanged by a scan.
REQ-030 SHALL drive match_data and match_index to zero when match_valid is low.

Reset
REQ-031 SHALL, when rst_n is low at a clock edge, enter IDLE and clear size, count, index, key, done, and match_valid to 0, including mid-scan (an unaccepted match is discarded).
REQ-032 SHALL give push_ready=1 and busy=0 in the first cycle after reset release.

Verification
REQ-033 SHALL cover: push 0x62617A ("baz"), 0x717578 ("qux"); start with key 0x62617A, match_ready=1 -> one match_valid with index 0, done 4 cycles after start, count=1, size=2.
REQ-034 SHALL cover: start on empty queue -> SCAN one cycle, done on the 2nd cycle after start, count=0, match_valid never high.
REQ-035 SHALL cover: fill 8 identical entries, 9th push with push_valid high -> push_ready=0, size=8; scan with match_ready toggling 1/0 -> 8 matches at indices 0..7 in order, count=8, each match held while stalled.
REQ-036 SHALL cover: push and clear asserted together in IDLE -> size=0; push and start during SCAN -> ignored, size unchanged.
REQ-037 SHALL cover: rst_n low while a match is stalled in SCAN -> next cycle state IDLE, match_valid=0, size=0, count=0, done never pulses.
